// File: rtl/tt_pkg.sv
// tt_pkg: shared widths and state encoding for the truth-table sweep capture.
package tt_pkg;
  localparam int TT_W = 16;
  localparam int IDX_W = 4;
  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;
endpackage

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: walks a 4-input function through all 16 vectors and records its truth table.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [TT_W-1:0] exp_tt,
  output logic            x0,
  output logic            x1,
  output logic            x2,
  output logic            x3,
  input  logic            y0,
  output logic            busy,
  output logic [TT_W-1:0] tt,
  output logic            done,
  output logic            match
);
  state_t state;
  logic [IDX_W-1:0] idx, xv;
  logic [3:0] cnt;
  logic [TT_W-1:0] exp_q, tt_n;
  logic last_beat;
  assign last_beat = cnt == 4'(SETTLE - 1);
  assign {x3, x2, x1, x0} = xv;
  // table as it will look once the current index is sampled; lets match see the final bit
  always_comb begin
    tt_n = tt;
    tt_n[idx] = y0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      xv <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      match <= 1'b0;
      tt <= '0;
      exp_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= DRIVE;
          idx <= '0;
          cnt <= '0;
          xv <= '0;
          tt <= '0;
          exp_q <= exp_tt;
          busy <= 1'b1;
          match <= 1'b0;
        end
        DRIVE: if (last_beat) begin
          tt <= tt_n;
          cnt <= '0;
          if (idx == IDX_W'(TT_W - 1)) begin
            state <= FINISH;
            xv <= '0;
            busy <= 1'b0;
            done <= 1'b1;
            match <= tt_n == exp_q;
          end else begin
            idx <= idx + 4'd1;
            xv <= idx + 4'd1;
          end
        end else begin
          cnt <= cnt + 4'd1;
        end
        FINISH: begin
          state <= IDLE;
          idx <= '0;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture: drives SETTLE=1 and SETTLE=3 instances against a truth-table reference.
module tb_tt_sweep_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [15:0] exp_tt = '0;
  wire [1:0][3:0] xv;
  wire [1:0][15:0] tt;
  wire [1:0] busy, done, match;
  logic [1:0] y0;
  int fsel = 0;
  logic [15:0] rtab = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // function under test, selected by fsel
  always_comb
    for (int k = 0; k < 2; k++)
      y0[k] = fsel == 0 ? xv[k][0] : fsel == 1 ? xv[k][3] & xv[k][2] : fsel == 2 ? 1'b0 : rtab[xv[k]];

  tt_sweep_capture #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .exp_tt(exp_tt),
    .x0(xv[0][0]), .x1(xv[0][1]), .x2(xv[0][2]), .x3(xv[0][3]), .y0(y0[0]),
    .busy(busy[0]), .tt(tt[0]), .done(done[0]), .match(match[0])
  );
  tt_sweep_capture #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .exp_tt(exp_tt),
    .x0(xv[1][0]), .x1(xv[1][1]), .x2(xv[1][2]), .x3(xv[1][3]), .y0(y0[1]),
    .busy(busy[1]), .tt(tt[1]), .done(done[1]), .match(match[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] model_tt();
    for (int i = 0; i < 16; i++)
      model_tt[i] = fsel == 0 ? i[0] : fsel == 1 ? i[3] & i[2] : fsel == 2 ? 1'b0 : rtab[i];
  endfunction

  task automatic sweep(input int k, input logic [15:0] e, input int rp);
    int s = k ? 3 : 1;
    int dcyc = -1, xbad = 0, bbad = 0;
    logic [15:0] want = model_tt();
    @(posedge clk); #1 start[k] = 1'b1; exp_tt = e;
    @(posedge clk); #1 start[k] = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == rp) begin start[k] = 1'b1; exp_tt = ~e; end
      else if (c == rp + 1) begin start[k] = 1'b0; exp_tt = e; end
      @(negedge clk);
      if (done[k]) begin dcyc = c; break; end
      if (xv[k] != 4'((c - 1) / s)) xbad++;
      if (!busy[k]) bbad++;
      @(posedge clk); #1;
    end
    start[k] = 1'b0;
    check("done_cycle", dcyc, 16 * s + 1);
    check("x_sequence", xbad, 0);
    check("busy_during", bbad, 0);
    check("busy_at_done", busy[k], 0);
    check("x_at_done", xv[k], 0);
    check("tt", tt[k], want);
    check("match", match[k], want == e);
    @(posedge clk); #1 exp_tt = 16'($urandom);
    @(negedge clk); check("done_pulse", done[k], 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tt_hold", tt[k], want);
    check("match_hold", match[k], want == e);
  endtask

  task automatic reset_mid(input int k, input logic [15:0] e);
    int dseen = 0;
    logic [15:0] want = model_tt();
    @(posedge clk); #1 start[k] = 1'b1; exp_tt = e;
    @(posedge clk); #1 start[k] = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_tt", tt[k], 0);
    check("rst_async_ctl", {busy[k], done[k], match[k], xv[k]}, 0);
    repeat (20) begin
      @(negedge clk);
      if (done[k]) dseen++;
    end
    check("no_done_abort", dseen, 0);
    @(posedge clk); #1 rst_n = 1'b1; start[k] = 1'b1; exp_tt = e;
    @(posedge clk); #1 start[k] = 1'b0;
    @(negedge clk); check("accept_after_rst", busy[k], 1);
    for (int c = 0; c < 60 && !done[k]; c++) @(negedge clk);
    check("post_rst_done", done[k], 1);
    check("post_rst_tt", tt[k], want);
    check("post_rst_match", match[k], want == e);
    @(posedge clk);
  endtask

  task automatic b2b(input int k, input logic [15:0] e);
    int s = k ? 3 : 1;
    int d0 = -1, d1 = -1, n = 0;
    logic [15:0] want = model_tt();
    @(posedge clk); #1 start[k] = 1'b1; exp_tt = e;
    for (int c = 0; c < 200 && n < 2; c++) begin
      @(negedge clk);
      if (done[k]) begin
        if (n == 0) d0 = c; else d1 = c;
        n++;
      end
      @(posedge clk); #1;
    end
    start[k] = 1'b0;
    check("b2b_first", d0, 16 * s + 1);
    check("b2b_gap", d1 - d0, 16 * s + 2);
    check("b2b_tt", tt[k], want);
    check("b2b_match", match[k], want == e);
    repeat (2) @(posedge clk);
    @(negedge clk); check("b2b_idle", busy[k], 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tt", tt, 0);
    check("reset_ctl", {busy, done, match, xv}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    fsel = 0;
    sweep(0, 16'hAAAA, 0);
    check("tt_x0", tt[0], 16'hAAAA);
    check("match_x0", match[0], 1);
    fsel = 1;
    sweep(1, 16'hF000, 0);
    check("tt_x3x2", tt[1], 16'hF000);
    check("match_x3x2", match[1], 1);
    fsel = 2;
    sweep(0, 16'h0001, 0);
    check("tt_zero", tt[0], 16'h0000);
    check("match_zero", match[0], 0);
    sweep(1, 16'h0001, 0);
    fsel = 0;
    sweep(0, 16'hAAAA, 5);
    sweep(1, 16'hAAAA, 5);
    reset_mid(0, 16'hAAAA);
    reset_mid(1, 16'h5555);
    fsel = 1;
    b2b(0, 16'hF000);
    b2b(1, 16'h1234);
    fsel = 3;
    for (int i = 0; i < 8; i++) begin
      rtab = 16'($urandom);
      sweep(i % 2, $urandom_range(0, 1) ? rtab : 16'($urandom), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
